spectrum_bar_draw: RTL and testbench

SPECTRUM_BAR_DRAW -- requirements
Module: spectrum_bar_draw

---
 rtl/spectrum_pkg.sv | 19 +
 rtl/bar_height_ram.sv | 26 ++
 rtl/spectrum_bar_draw.sv | 229 ++++++++++++++++++++++
 tb/tb_spectrum_bar_draw.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spectrum_pkg.sv
// Shared colours, fetch FSM state encoding and bar-geometry defaults for the spectrum bar renderer.
package spectrum_pkg;

    localparam int BAR_NUM_DEF = 64;
    localparam int H_MAX_DEF   = 400;

    localparam logic [15:0] RGB_FG = 16'hF800;
    localparam logic [15:0] RGB_BG = 16'h0000;
    localparam logic [15:0] RGB_PK = 16'hFFFF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_CALC,
        ST_DONE
    } fetch_state_e;

endpackage

// File: rtl/bar_height_ram.sv
// 64x9 simple dual-port RAM: synchronous write, asynchronous read.
// A read of the address being written in the same cycle returns the old word.
module bar_height_ram #(
    parameter int DEPTH = 64,
    parameter int AW    = 6,
    parameter int DW    = 9
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/spectrum_bar_draw.sv
// Fetches spectrum magnitudes into a bar-height RAM and renders RGB565 bars, 1-cycle pixel latency.
// Optional peak-hold markers are enabled with SPECTRUM_PEAK_HOLD_EN.
module spectrum_bar_draw
    import spectrum_pkg::*;
#(
    parameter int          BAR_NUM   = BAR_NUM_DEF,
    parameter int          BAR_W     = 7,
    parameter int          X0        = 16,
    parameter int          Y_BASE    = 460,
    parameter int          H_MAX     = H_MAX_DEF,
    parameter int          MAG_SHIFT = 4,
    parameter int          RD_LAT    = 3,
    parameter logic [15:0] FG        = RGB_FG,
    parameter logic [15:0] BG        = RGB_BG,
    parameter logic [15:0] PK        = RGB_PK
) (
    input  logic        lcd_clk,
    input  logic        rst,
    input  logic        fifo_empty,
    input  logic [15:0] fifo_q,
    input  logic [6:0]  rd_cnt,
    output logic        data_req,
    output logic        wr_over,
    input  logic [10:0] pixel_xpos,
    input  logic [10:0] pixel_ypos,
    output logic [15:0] pixel_data
);

    localparam int WCW = 4;

    fetch_state_e   st_q;
    logic           fe_q;
    logic           data_req_q;
    logic           wr_over_q;
    logic [6:0]     idx_q;
    logic [WCW-1:0] wcnt_q;
    logic [15:0]    mag_q;
    logic           clr_busy_q;
    logic [5:0]     clr_idx_q;

    logic [15:0]    mag_sh;
    logic [8:0]     h_calc;
    logic           ram_we;
    logic [5:0]     ram_waddr;
    logic [8:0]     ram_wdata;

    logic [10:0]    px_prev_q;
    logic [6:0]     col_q, col_d;
    logic [3:0]     sub_q, sub_d;
    logic           col_ok_q, col_ok_d;
    logic [8:0]     h_rd;
    logic [11:0]    y12;
    logic [15:0]    pix_q, pix_d;

    assign mag_sh = mag_q >> MAG_SHIFT;
    assign h_calc = (mag_sh > 16'(H_MAX)) ? 9'(H_MAX) : mag_sh[8:0];

    // fifo_empty is staged once, so a fresh non-empty indication reaches REQ on the second cycle.
    always_ff @(posedge lcd_clk) begin
        if (rst) begin
            st_q       <= ST_IDLE;
            fe_q       <= 1'b1;
            data_req_q <= 1'b0;
            wr_over_q  <= 1'b0;
            idx_q      <= '0;
            wcnt_q     <= '0;
            mag_q      <= '0;
            clr_busy_q <= 1'b1;
            clr_idx_q  <= '0;
        end else begin
            fe_q       <= fifo_empty;
            data_req_q <= 1'b0;
            wr_over_q  <= 1'b0;
            if (clr_busy_q) begin
                clr_idx_q <= clr_idx_q + 6'd1;
                if (clr_idx_q == 6'd63) begin
                    clr_busy_q <= 1'b0;
                end
            end
            case (st_q)
                ST_IDLE: begin
                    if (!clr_busy_q && !fe_q) begin
                        st_q       <= ST_REQ;
                        data_req_q <= 1'b1;
                    end
                end
                ST_REQ: begin
                    idx_q  <= rd_cnt;
                    wcnt_q <= WCW'(RD_LAT - 1);
                    st_q   <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (wcnt_q == '0) begin
                        mag_q <= fifo_q;
                        st_q  <= ST_CALC;
                    end else begin
                        wcnt_q <= wcnt_q - 1'b1;
                    end
                end
                ST_CALC: begin
                    st_q      <= ST_DONE;
                    wr_over_q <= 1'b1;
                end
                ST_DONE: begin
                    st_q <= ST_IDLE;
                end
                default: begin
                    st_q <= ST_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        ram_we    = 1'b0;
        ram_waddr = idx_q[5:0];
        ram_wdata = h_calc;
        if (!rst && clr_busy_q) begin
            ram_we    = 1'b1;
            ram_waddr = clr_idx_q;
            ram_wdata = '0;
        end else if (!rst && st_q == ST_CALC && idx_q < 7'(BAR_NUM)) begin
            ram_we = 1'b1;
        end
    end

    // Column tracking follows a scan that starts at X0 and steps by one pixel (or repeats).
    always_comb begin
        col_d    = col_q;
        sub_d    = sub_q;
        col_ok_d = 1'b0;
        if (pixel_xpos == 11'(X0)) begin
            col_d    = '0;
            sub_d    = '0;
            col_ok_d = 1'b1;
        end else if (col_ok_q && pixel_xpos == px_prev_q) begin
            col_ok_d = 1'b1;
        end else if (col_ok_q && pixel_xpos == px_prev_q + 11'd1) begin
            if (sub_q == 4'(BAR_W - 1)) begin
                col_d    = col_q + 7'd1;
                sub_d    = '0;
                col_ok_d = (col_q != 7'(BAR_NUM - 1));
            end else begin
                sub_d    = sub_q + 4'd1;
                col_ok_d = 1'b1;
            end
        end
    end

    bar_height_ram u_height_ram (
        .clk     (lcd_clk),
        .we_i    (ram_we),
        .waddr_i (ram_waddr),
        .wdata_i (ram_wdata),
        .raddr_i (col_d[5:0]),
        .rdata_o (h_rd)
    );

    assign y12 = {1'b0, pixel_ypos};

`ifdef SPECTRUM_PEAK_HOLD_EN
    logic [8:0] pk_shadow_q [64];
    logic [3:0] pk_cnt_q    [64];
    logic [8:0] pk_max;
    logic [8:0] pk_wdata;
    logic [8:0] pk_rd;

    // Write-side copy of the peaks, so the update does not steal the display read port.
    always_comb begin
        pk_max   = (h_calc > pk_shadow_q[idx_q[5:0]]) ? h_calc : pk_shadow_q[idx_q[5:0]];
        pk_wdata = pk_max;
        if (pk_cnt_q[idx_q[5:0]] == 4'd15 && pk_max != 9'd0) begin
            pk_wdata = pk_max - 9'd1;
        end
        if (clr_busy_q) begin
            pk_wdata = '0;
        end
    end

    always_ff @(posedge lcd_clk) begin
        if (ram_we) begin
            pk_shadow_q[ram_waddr] <= pk_wdata;
            pk_cnt_q[ram_waddr]    <= clr_busy_q ? 4'd0 : pk_cnt_q[ram_waddr] + 4'd1;
        end
    end

    bar_height_ram u_peak_ram (
        .clk     (lcd_clk),
        .we_i    (ram_we),
        .waddr_i (ram_waddr),
        .wdata_i (pk_wdata),
        .raddr_i (col_d[5:0]),
        .rdata_o (pk_rd)
    );
`endif

    always_comb begin
        pix_d = BG;
        if (col_ok_d && y12 <= 12'(Y_BASE) && (y12 + {3'b000, h_rd}) >= 12'(Y_BASE)) begin
            pix_d = FG;
        end
`ifdef SPECTRUM_PEAK_HOLD_EN
        if (col_ok_d && (y12 + {3'b000, pk_rd}) == 12'(Y_BASE)) begin
            pix_d = PK;
        end
`endif
    end

    always_ff @(posedge lcd_clk) begin
        if (rst) begin
            px_prev_q <= '0;
            col_q     <= '0;
            sub_q     <= '0;
            col_ok_q  <= 1'b0;
            pix_q     <= BG;
        end else begin
            px_prev_q <= pixel_xpos;
            col_q     <= col_d;
            sub_q     <= sub_d;
            col_ok_q  <= col_ok_d;
            pix_q     <= pix_d;
        end
    end

    assign data_req   = data_req_q;
    assign wr_over    = wr_over_q;
    assign pixel_data = pix_q;

endmodule

// File: tb/tb_spectrum_bar_draw.sv
// Directed bench for spectrum_bar_draw: fetch handshake timing, height saturation, pixel rendering.
module tb_spectrum_bar_draw;

    localparam int X0 = 16;
    localparam int BW = 7;
    localparam logic [15:0] C_FG = 16'hF800;
    localparam logic [15:0] C_BG = 16'h0000;
`ifdef SPECTRUM_PEAK_HOLD_EN
    localparam logic [15:0] TOP_C  = 16'hFFFF;
    localparam logic [15:0] BASE_C = 16'hFFFF;
`else
    localparam logic [15:0] TOP_C  = 16'hF800;
    localparam logic [15:0] BASE_C = 16'hF800;
`endif

    logic        lcd_clk = 1'b0;
    logic        rst;
    logic        fifo_empty;
    logic [15:0] fifo_q;
    logic [6:0]  rd_cnt;
    logic        data_req;
    logic        wr_over;
    logic [10:0] pixel_xpos;
    logic [10:0] pixel_ypos;
    logic [15:0] pixel_data;

    int n_vec = 0;
    int n_bad = 0;

    always #5 lcd_clk = ~lcd_clk;

    spectrum_bar_draw dut (
        .lcd_clk    (lcd_clk),
        .rst        (rst),
        .fifo_empty (fifo_empty),
        .fifo_q     (fifo_q),
        .rd_cnt     (rd_cnt),
        .data_req   (data_req),
        .wr_over    (wr_over),
        .pixel_xpos (pixel_xpos),
        .pixel_ypos (pixel_ypos),
        .pixel_data (pixel_data)
    );

    // Scan x from X0 to x; y is only valid on the final pixel, then both move away.
    task automatic probe(input int x, input int y, output logic [15:0] c);
        pixel_ypos = 11'd0;
        for (int xi = X0; xi <= x; xi++) begin
            @(posedge lcd_clk);
            #1;
            pixel_xpos = 11'(xi);
            if (xi == x) pixel_ypos = 11'(y);
        end
        @(posedge lcd_clk);
        #1;
        pixel_xpos = 11'd0;
        pixel_ypos = 11'd0;
        @(negedge lcd_clk);
        c = pixel_data;
    endtask

    task automatic wait_req();
        for (int i = 0; i < 200; i++) begin
            @(negedge lcd_clk);
            if (data_req === 1'b1) return;
        end
        n_vec++;
        n_bad++;
        $display("FAIL wait_req: data_req=%b after 200 cycles, required 1", data_req);
    endtask

    // Entered at the negedge where data_req is seen high.
    task automatic finish_txn(input logic [15:0] val);
        @(negedge lcd_clk);
        n_vec++;
        if (data_req !== 1'b0) begin
            n_bad++;
            $display("FAIL req_width: data_req=%b required 0", data_req);
        end
        rd_cnt = rd_cnt ^ 7'h15;
        @(negedge lcd_clk);
        @(negedge lcd_clk);
        fifo_q = val;
        @(negedge lcd_clk);
        fifo_q = 16'hDEAD;
        n_vec++;
        if (wr_over !== 1'b0) begin
            n_bad++;
            $display("FAIL wr_over_early: wr_over=%b required 0", wr_over);
        end
        @(negedge lcd_clk);
        n_vec++;
        if (wr_over !== 1'b1 || data_req !== 1'b0) begin
            n_bad++;
            $display("FAIL wr_over_pulse: wr_over=%b data_req=%b required 1 0", wr_over, data_req);
        end
        @(negedge lcd_clk);
        n_vec++;
        if (wr_over !== 1'b0 || data_req !== 1'b0) begin
            n_bad++;
            $display("FAIL done_gap: wr_over=%b data_req=%b required 0 0", wr_over, data_req);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        fifo_empty = 1'b0;
        fifo_q = 16'hDEAD;
        rd_cnt = 7'd5;
        pixel_xpos = 11'(X0);
        pixel_ypos = 11'd460;
        repeat (4) @(negedge lcd_clk);
        n_vec++;
        if (data_req !== 1'b0 || wr_over !== 1'b0 || pixel_data !== C_BG) begin
            n_bad++;
            $display("FAIL reset_state: data_req=%b wr_over=%b pixel=%h required 0 0 %h",
                     data_req, wr_over, pixel_data, C_BG);
        end
    endtask

    task automatic test_first_fetch();
        logic [15:0] c;
        int early;
        early = 0;
        @(posedge lcd_clk);
        #1;
        rst = 1'b0;
        pixel_xpos = 11'd0;
        pixel_ypos = 11'd0;
        for (int i = 0; i <= 64; i++) begin
            @(negedge lcd_clk);
            if (data_req !== 1'b0) early++;
        end
        n_vec++;
        if (early != 0) begin
            n_bad++;
            $display("FAIL clear_sweep_hold: data_req high in %0d cycles, required 0", early);
        end
        @(negedge lcd_clk);
        n_vec++;
        if (data_req !== 1'b1) begin
            n_bad++;
            $display("FAIL first_req: data_req=%b required 1", data_req);
        end
        fifo_empty = 1'b1;
        finish_txn(16'h0320);
        probe(X0 + 5 * BW, 410, c);
        n_vec++;
        if (c !== TOP_C) begin n_bad++; $display("FAIL bar5_top: pixel=%h required %h", c, TOP_C); end
        probe(X0 + 5 * BW, 409, c);
        n_vec++;
        if (c !== C_BG) begin n_bad++; $display("FAIL bar5_above: pixel=%h required %h", c, C_BG); end
        probe(X0 + 5 * BW + 3, 460, c);
        n_vec++;
        if (c !== C_FG) begin n_bad++; $display("FAIL bar5_base: pixel=%h required %h", c, C_FG); end
    endtask

    task automatic test_saturate();
        logic [15:0] c;
        rd_cnt = 7'd0;
        fifo_empty = 1'b0;
        wait_req();
        fifo_empty = 1'b1;
        finish_txn(16'hFFFF);
        probe(X0, 60, c);
        n_vec++;
        if (c !== TOP_C) begin n_bad++; $display("FAIL sat_top: pixel=%h required %h", c, TOP_C); end
        probe(X0, 59, c);
        n_vec++;
        if (c !== C_BG) begin n_bad++; $display("FAIL sat_above: pixel=%h required %h", c, C_BG); end
        probe(X0 + BW - 1, 60, c);
        n_vec++;
        if (c !== TOP_C) begin n_bad++; $display("FAIL bar0_last_col: pixel=%h required %h", c, TOP_C); end
        probe(X0 + BW, 60, c);
        n_vec++;
        if (c !== C_BG) begin n_bad++; $display("FAIL bar1_first_col: pixel=%h required %h", c, C_BG); end
        probe(X0 - 1, 200, c);
        n_vec++;
        if (c !== C_BG) begin n_bad++; $display("FAIL left_of_x0: pixel=%h required %h", c, C_BG); end
    endtask

    task automatic test_empty_hold();
        logic [15:0] c;
        int seen;
        seen = 0;
        fifo_empty = 1'b1;
        rd_cnt = 7'd63;
        for (int i = 0; i < 40; i++) begin
            @(negedge lcd_clk);
            if (data_req !== 1'b0) seen++;
        end
        n_vec++;
        if (seen != 0) begin
            n_bad++;
            $display("FAIL empty_hold: data_req high in %0d cycles, required 0", seen);
        end
        @(posedge lcd_clk);
        #1;
        fifo_empty = 1'b0;
        @(negedge lcd_clk);
        @(negedge lcd_clk);
        n_vec++;
        if (data_req !== 1'b0) begin n_bad++; $display("FAIL req_1st_cycle: data_req=%b required 0", data_req); end
        @(negedge lcd_clk);
        n_vec++;
        if (data_req !== 1'b1) begin n_bad++; $display("FAIL req_2nd_cycle: data_req=%b required 1", data_req); end
        fifo_empty = 1'b1;
        finish_txn(16'h0100);
        probe(X0 + 63 * BW, 444, c);
        n_vec++;
        if (c !== TOP_C) begin n_bad++; $display("FAIL bar63_top: pixel=%h required %h", c, TOP_C); end
        probe(X0 + 63 * BW, 443, c);
        n_vec++;
        if (c !== C_BG) begin n_bad++; $display("FAIL bar63_above: pixel=%h required %h", c, C_BG); end
        probe(X0 + 64 * BW, 450, c);
        n_vec++;
        if (c !== C_BG) begin n_bad++; $display("FAIL past_last_bar: pixel=%h required %h", c, C_BG); end
    endtask

    task automatic test_out_of_range();
        logic [15:0] c;
        rd_cnt = 7'd70;
        fifo_empty = 1'b0;
        wait_req();
        fifo_empty = 1'b1;
        finish_txn(16'h0640);
        probe(X0 + 6 * BW, 400, c);
        n_vec++;
        if (c !== C_BG) begin n_bad++; $display("FAIL idx70_no_write: pixel=%h required %h", c, C_BG); end
        probe(X0 + 6 * BW, 460, c);
        n_vec++;
        if (c !== BASE_C) begin n_bad++; $display("FAIL idx70_base: pixel=%h required %h", c, BASE_C); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] c;
        rd_cnt = 7'd1;
        fifo_empty = 1'b0;
        wait_req();
        finish_txn(16'h0200);
        rd_cnt = 7'd2;
        @(negedge lcd_clk);
        n_vec++;
        if (data_req !== 1'b1) begin n_bad++; $display("FAIL b2b_req: data_req=%b required 1", data_req); end
        fifo_empty = 1'b1;
        finish_txn(16'h0300);
        probe(X0 + BW, 428, c);
        n_vec++;
        if (c !== TOP_C) begin n_bad++; $display("FAIL bar1_top: pixel=%h required %h", c, TOP_C); end
        probe(X0 + BW, 427, c);
        n_vec++;
        if (c !== C_BG) begin n_bad++; $display("FAIL bar1_above: pixel=%h required %h", c, C_BG); end
        probe(X0 + 2 * BW, 412, c);
        n_vec++;
        if (c !== TOP_C) begin n_bad++; $display("FAIL bar2_top: pixel=%h required %h", c, TOP_C); end
        probe(X0 + 2 * BW, 411, c);
        n_vec++;
        if (c !== C_BG) begin n_bad++; $display("FAIL bar2_above: pixel=%h required %h", c, C_BG); end
    endtask

    task automatic test_abort();
        logic [15:0] c;
        int seen;
        seen = 0;
        rd_cnt = 7'd3;
        fifo_empty = 1'b0;
        wait_req();
        fifo_empty = 1'b1;
        fifo_q = 16'h0320;
        @(negedge lcd_clk);
        rst = 1'b1;
        for (int i = 0; i < 80; i++) begin
            @(negedge lcd_clk);
            if (i == 2) rst = 1'b0;
            if (wr_over !== 1'b0 || data_req !== 1'b0) seen++;
        end
        fifo_q = 16'hDEAD;
        n_vec++;
        if (seen != 0) begin
            n_bad++;
            $display("FAIL abort_strobes: wr_over/data_req high in %0d cycles, required 0", seen);
        end
        probe(X0 + 3 * BW, 459, c);
        n_vec++;
        if (c !== C_BG) begin n_bad++; $display("FAIL abort_no_write: pixel=%h required %h", c, C_BG); end
        probe(X0 + 63 * BW, 444, c);
        n_vec++;
        if (c !== C_BG) begin n_bad++; $display("FAIL clear_bar63: pixel=%h required %h", c, C_BG); end
        probe(X0, 60, c);
        n_vec++;
        if (c !== C_BG) begin n_bad++; $display("FAIL clear_bar0: pixel=%h required %h", c, C_BG); end
        probe(X0, 460, c);
        n_vec++;
        if (c !== BASE_C) begin n_bad++; $display("FAIL clear_bar0_base: pixel=%h required %h", c, BASE_C); end
    endtask

`ifdef SPECTRUM_PEAK_HOLD_EN
    task automatic test_peak();
        logic [15:0] c;
        for (int k = 0; k < 17; k++) begin
            rd_cnt = 7'd0;
            fifo_empty = 1'b0;
            wait_req();
            fifo_empty = 1'b1;
            finish_txn((k == 0) ? 16'h0640 : 16'h0000);
        end
        probe(X0, 361, c);
        n_vec++;
        if (c !== 16'hFFFF) begin n_bad++; $display("FAIL peak_99: pixel=%h required FFFF", c); end
        probe(X0, 360, c);
        n_vec++;
        if (c !== C_BG) begin n_bad++; $display("FAIL peak_above: pixel=%h required %h", c, C_BG); end
        probe(X0, 460, c);
        n_vec++;
        if (c !== C_FG) begin n_bad++; $display("FAIL peak_base: pixel=%h required %h", c, C_FG); end
    endtask
`endif

    initial begin
        test_reset();
        test_first_fetch();
        test_saturate();
        test_empty_hold();
        test_out_of_range();
        test_back_to_back();
        test_abort();
`ifdef SPECTRUM_PEAK_HOLD_EN
        test_peak();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
